// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory slave.
package spi_pkg;

  // Frame sequencing: idle, read/write bit, address bits, data words.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  // SPI modes encoded as {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Modes 0 and 3 sample MOSI on the rising SCLK edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    case (mode)
      MODE0, MODE3: return 1'b1;
      MODE1, MODE2: return 1'b0;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous bit, with rise/fall detect on the synchronised copy.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw input down the chain; remember the last synchronised value for edge detect.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Synchroniser and edge-history flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave fronting a DEPTH x DATA_W register file: RW bit, address, then a burst of data words.
module spi_mem_slave
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int AUTO_INC    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              BUSY,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              ABORT
);

  localparam int   DEPTH       = 2 ** ADDR_W;
  localparam int   CNT_W       = $clog2(max_int(ADDR_W, DATA_W) + 1);
  localparam logic SAMPLE_RISE = sample_on_rise({1'(CPOL), 1'(CPHA)});

  // Synchronised pins and edge strobes
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sample_edge, shift_edge;

  // Frame state
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                abort_q, abort_d;

  // Register file and its single write port
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Shifted / advanced views of the datapath registers
  logic [ADDR_W-1:0]   addr_shift, addr_inc;
  logic [DATA_W-1:0]   rx_shift, tx_shift;
  logic                addr_last, data_last;

  // SCLK idles at CPOL, so no spurious edge comes out of reset.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sclk_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .din  (SCLK),
    .dout (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // CS resets as if asserted: a CS held low through reset produces no falling
  // edge, so a new frame only starts after CS has been seen high again.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .din  (CS),
    .dout (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI goes through the same depth as SCLK so data and clock stay aligned.
  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end

  // MOSI synchroniser chain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) mosi_sync_q <= '0;
    else        mosi_sync_q <= mosi_sync_d;
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // An edge is a sample edge when SCLK has just moved to the sampling level; CS high masks everything.
  assign sample_edge = (sclk_rise | sclk_fall) & (sclk_s == SAMPLE_RISE) & ~cs_s;
  assign shift_edge  = (sclk_rise | sclk_fall) & (sclk_s != SAMPLE_RISE) & ~cs_s;

  assign addr_shift = ADDR_W'({addr_q, mosi_s});
  assign rx_shift   = DATA_W'({rx_q, mosi_s});
  assign tx_shift   = DATA_W'({tx_q, 1'b0});
  assign addr_inc   = (AUTO_INC != 0) ? addr_q + ADDR_W'(1) : addr_q;
  assign addr_last  = (cnt_q == CNT_W'(ADDR_W - 1));
  assign data_last  = (cnt_q == CNT_W'(DATA_W - 1));

  // Next-state, datapath and strobe logic; CS rising overrides any same-cycle SCLK edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = (state_q == S_DATA && rw_q) ? miso_q : 1'b0;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    abort_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = rx_shift;

    if (state_q != S_IDLE && cs_rise) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      // Anything after the RW bit and short of a word boundary is a truncated transfer.
      abort_d = (state_q == S_ADDR) || (state_q == S_DATA && cnt_q != '0);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (sample_edge) begin
            rw_d    = mosi_s;
            state_d = S_ADDR;
            cnt_d   = '0;
          end
        end
        S_ADDR: begin
          if (sample_edge) begin
            addr_d = addr_shift;
            if (addr_last) begin
              state_d = S_DATA;
              cnt_d   = '0;
              if (rw_q) tx_d = mem_q[addr_shift];
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_DATA: begin
          if (!rw_q) begin
            if (sample_edge) begin
              rx_d = rx_shift;
              if (data_last) begin
                mem_we    = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
                addr_d    = addr_inc;
                cnt_d     = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end else begin
            if (shift_edge) begin
              miso_d = tx_q[DATA_W-1];
              tx_d   = tx_shift;
            end else if (sample_edge) begin
              if (data_last) begin
                // Reload before the next shift edge so the following word streams without a gap.
                addr_d = addr_inc;
                tx_d   = mem_q[addr_inc];
                cnt_d  = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Frame state and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      abort_q   <= abort_d;
    end
  end

  // Register file; cleared by reset, so it is built from flops rather than block RAM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign MISO    = miso_q;
  assign BUSY    = (state_q != S_IDLE);
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = wr_addr_q;
  assign ABORT   = abort_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench: four slaves (mode 0, mode 3, mode 1, mode 0 without auto-increment) share CLK, RST_N and MOSI.
module tb_spi_mem_slave;

  logic       clk;
  logic       rst_n;
  logic       mosi;
  logic [3:0] sclk_v;
  logic [3:0] cs_v;
  logic [3:0] miso_v;
  logic [3:0] busy_v;
  logic [3:0] wr_stb_v;
  logic [3:0] abort_v;
  logic [6:0] wr_addr_a [4];

  int         checks = 0;
  int         failures = 0;
  int         wr_cnt [4] = '{0, 0, 0, 0};
  int         abort_cnt [4] = '{0, 0, 0, 0};
  logic [6:0] last_wr [4] = '{7'h0, 7'h0, 7'h0, 7'h0};
  int         miso_hi_cnt3 = 0;
  int         hi_before;
  bit         last_mi;
  logic [7:0] rx_byte;

  spi_mem_slave #(.CPOL(0), .CPHA(0), .AUTO_INC(1)) u0 (
    .CLK(clk), .RST_N(rst_n), .SCLK(sclk_v[0]), .CS(cs_v[0]), .MOSI(mosi), .MISO(miso_v[0]),
    .BUSY(busy_v[0]), .WR_STB(wr_stb_v[0]), .WR_ADDR(wr_addr_a[0]), .ABORT(abort_v[0]));
  spi_mem_slave #(.CPOL(1), .CPHA(1), .AUTO_INC(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .SCLK(sclk_v[1]), .CS(cs_v[1]), .MOSI(mosi), .MISO(miso_v[1]),
    .BUSY(busy_v[1]), .WR_STB(wr_stb_v[1]), .WR_ADDR(wr_addr_a[1]), .ABORT(abort_v[1]));
  spi_mem_slave #(.CPOL(0), .CPHA(1), .AUTO_INC(1)) u2 (
    .CLK(clk), .RST_N(rst_n), .SCLK(sclk_v[2]), .CS(cs_v[2]), .MOSI(mosi), .MISO(miso_v[2]),
    .BUSY(busy_v[2]), .WR_STB(wr_stb_v[2]), .WR_ADDR(wr_addr_a[2]), .ABORT(abort_v[2]));
  spi_mem_slave #(.CPOL(0), .CPHA(0), .AUTO_INC(0)) u3 (
    .CLK(clk), .RST_N(rst_n), .SCLK(sclk_v[3]), .CS(cs_v[3]), .MOSI(mosi), .MISO(miso_v[3]),
    .BUSY(busy_v[3]), .WR_STB(wr_stb_v[3]), .WR_ADDR(wr_addr_a[3]), .ABORT(abort_v[3]));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse monitors, sampled on the falling CLK edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_stb_v[i]) begin
        wr_cnt[i]++;
        last_wr[i] = wr_addr_a[i];
      end
      if (abort_v[i]) abort_cnt[i]++;
    end
    if (!cs_v[3] && miso_v[3]) miso_hi_cnt3++;
  end

  function automatic bit cpol_of(input int u);
    return (u == 1);
  endfunction

  function automatic bit cpha_of(input int u);
    return (u == 1 || u == 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One SCLK period; MISO is captured just before the sample edge, as a master would.
  task automatic xfer_bit(input int u, input bit mo);
    if (!cpha_of(u)) begin
      mosi = mo;
      #100;
      last_mi = miso_v[u];
      sclk_v[u] = ~cpol_of(u);
      #100;
      sclk_v[u] = cpol_of(u);
    end else begin
      sclk_v[u] = ~cpol_of(u);
      mosi = mo;
      #100;
      last_mi = miso_v[u];
      sclk_v[u] = cpol_of(u);
      #100;
    end
  endtask

  task automatic xfer_byte(input int u, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(u, v[i]);
      rx_byte[i] = last_mi;
    end
  endtask

  task automatic begin_frame(input int u, input bit rw, input logic [6:0] a);
    cs_v[u] = 1'b0;
    #100;
    xfer_bit(u, rw);
    for (int i = 6; i >= 0; i--) xfer_bit(u, a[i]);
  endtask

  task automatic end_frame(input int u);
    mosi = 1'b0;
    #100;
    cs_v[u] = 1'b1;
    #200;
  endtask

  task automatic write_frame(input int u, input logic [6:0] a, input logic [7:0] d);
    begin_frame(u, 1'b0, a);
    xfer_byte(u, d);
    check($sformatf("u%0d_busy_in_frame", u), 32'(busy_v[u]), 32'd1);
    end_frame(u);
    $display("WRITE u%0d addr=%02h data=%02h", u, a, d);
  endtask

  task automatic read_frame(input int u, input logic [6:0] a);
    begin_frame(u, 1'b1, a);
    xfer_byte(u, 8'h00);
    end_frame(u);
    $display("READ  u%0d addr=%02h data=%02h", u, a, rx_byte);
  endtask

  initial begin
    rst_n  = 1'b0;
    mosi   = 1'b0;
    cs_v   = 4'b1111;
    sclk_v = 4'b0010;
    #100;
    rst_n = 1'b1;
    #100;

    // Reset values
    check("rst_miso",    32'(miso_v[0]),    32'd0);
    check("rst_busy",    32'(busy_v[0]),    32'd0);
    check("rst_wr_stb",  32'(wr_stb_v[0]),  32'd0);
    check("rst_wr_addr", 32'(wr_addr_a[0]), 32'd0);
    check("rst_abort",   32'(abort_v[0]),   32'd0);

    // Mode 0 single write then read-back
    write_frame(0, 7'h55, 8'h33);
    check("t1_wr_cnt",  32'(wr_cnt[0]),  32'd1);
    check("t1_wr_addr", 32'(last_wr[0]), 32'h55);
    check("t1_busy_after", 32'(busy_v[0]), 32'd0);
    read_frame(0, 7'h55);
    check("t1_read", 32'(rx_byte), 32'h33);

    // CS pulse with no SCLK: no abort
    cs_v[0] = 1'b0;
    #300;
    cs_v[0] = 1'b1;
    #200;
    $display("EMPTY u0 frame");
    check("empty_frame_abort", 32'(abort_cnt[0]), 32'd0);

    // Burst write across the address wrap, then burst read
    begin_frame(0, 1'b0, 7'h7F);
    xfer_byte(0, 8'hA1);
    check("t2_wr_addr0", 32'(last_wr[0]), 32'h7F);
    xfer_byte(0, 8'hB2);
    check("t2_wr_addr1", 32'(last_wr[0]), 32'h00);
    xfer_byte(0, 8'hC3);
    check("t2_wr_addr2", 32'(last_wr[0]), 32'h01);
    end_frame(0);
    $display("BURST WRITE u0 addr=7f data=a1,b2,c3");
    check("t2_wr_cnt", 32'(wr_cnt[0]), 32'd4);
    begin_frame(0, 1'b1, 7'h7F);
    xfer_byte(0, 8'h00);
    check("t2_read0", 32'(rx_byte), 32'hA1);
    xfer_byte(0, 8'h00);
    check("t2_read1", 32'(rx_byte), 32'hB2);
    xfer_byte(0, 8'h00);
    check("t2_read2", 32'(rx_byte), 32'hC3);
    end_frame(0);
    $display("BURST READ u0 addr=7f");
    check("t2_abort", 32'(abort_cnt[0]), 32'd0);

    // Truncated write aborts and leaves memory alone
    write_frame(0, 7'h10, 8'h11);
    begin_frame(0, 1'b0, 7'h10);
    for (int i = 0; i < 5; i++) xfer_bit(0, 1'b1);
    end_frame(0);
    $display("ABORTED WRITE u0 addr=10 after 5 bits");
    check("t3_abort_cnt", 32'(abort_cnt[0]), 32'd1);
    check("t3_wr_cnt",    32'(wr_cnt[0]),    32'd5);
    read_frame(0, 7'h10);
    check("t3_read", 32'(rx_byte), 32'h11);

    // Reset in the middle of a read data phase
    begin_frame(0, 1'b1, 7'h55);
    for (int i = 0; i < 3; i++) xfer_bit(0, 1'b0);
    #100;
    check("t4_miso_before", 32'(miso_v[0]), 32'd1);
    check("t4_busy_before", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_miso_rst", 32'(miso_v[0]), 32'd0);
    check("t4_busy_rst", 32'(busy_v[0]), 32'd0);
    cs_v[0] = 1'b1;
    #100;
    rst_n = 1'b1;
    #200;
    $display("RESET u0 during read");
    read_frame(0, 7'h55);
    check("t4_read55", 32'(rx_byte), 32'h00);
    read_frame(0, 7'h7F);
    check("t4_read7f", 32'(rx_byte), 32'h00);

    // Mode 3 and mode 1 repeat the write/read pair
    for (int u = 1; u <= 2; u++) begin
      write_frame(u, 7'h55, 8'h33);
      check($sformatf("t5_u%0d_wr_cnt", u),  32'(wr_cnt[u]),  32'd1);
      check($sformatf("t5_u%0d_wr_addr", u), 32'(last_wr[u]), 32'h55);
      read_frame(u, 7'h55);
      check($sformatf("t5_u%0d_read", u), 32'(rx_byte), 32'h33);
    end

    // Held address: both words land on 0x20
    hi_before = miso_hi_cnt3;
    begin_frame(3, 1'b0, 7'h20);
    xfer_byte(3, 8'h01);
    check("t6_wr_addr0", 32'(last_wr[3]), 32'h20);
    xfer_byte(3, 8'h02);
    check("t6_wr_addr1", 32'(last_wr[3]), 32'h20);
    check("t6_wr_cnt",   32'(wr_cnt[3]),  32'd2);
    end_frame(3);
    $display("BURST WRITE u3 addr=20 data=01,02");
    check("t6_miso_quiet", 32'(miso_hi_cnt3), 32'(hi_before));
    read_frame(3, 7'h20);
    check("t6_read", 32'(rx_byte), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
